mem_dump_reader: RTL and testbench
==================================

Name: mem_dump_reader

Overview:
- Read-back end of the pipe_MIPS32 memory interface. Program loading writes words into Mem; this block reads a window of Mem back out once the CPU has halted.
- Each word is streamed as an (address, data) pair over a valid/ready port to the debug/host side.
- Sits beside the CPU data memory on a dedicated synchronous read port. It replaces hierarchical peeks at Mem in benches and on-chip debug.

Parameters:
- ADDR_W, 10, word-address width of Mem (1024 words).
- DATA_W, 32, memory word width.

Ports:
- clk1  in  1  single system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- halted  in  1  CPU HALTED flag (level).
- dump_en  in  1  one-cycle request to arm a dump.
- start_addr  in  ADDR_W  first word address; sampled with dump_en.
- word_count  in  ADDR_W+1  number of words to dump, 0..2^ADDR_W; sampled with dump_en.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  DATA_W  read data; valid exactly 1 cycle after mem_rd_en.
- out_valid  out  1  output word valid.
- out_ready  in  1  sink accepts the output word.
- out_addr  out  ADDR_W  address of the current output word.
- out_data  out  DATA_W  data of the current output word.
- out_last  out  1  marks the final word of the dump.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a dump ends.
- aborted  out  1  sticky; set if halted dropped mid-dump; cleared on the next accepted dump_en.

Behaviour:
- Clock and reset: one clock, clk1. Reset is asynchronous and active-low on rst_n.
- Reset state: IDLE, with all outputs 0. Reset during any state aborts immediately: no done pulse, and out_valid drops asynchronously.
- States: IDLE, ARM, READ, WAIT, SEND, DONE.
- IDLE:
  - dump_en=1 latches start_addr into cur_addr, latches word_count into remaining, clears aborted, then goes to ARM.
  - dump_en in any other state is ignored.
- ARM:
  - remaining==0 goes to DONE; no words are emitted.
  - Otherwise, halted=1 goes to READ; halted=0 stays in ARM indefinitely.
- READ (1 cycle): mem_rd_en=1, mem_rd_addr=cur_addr. Goes to WAIT.
- WAIT (1 cycle):
  - Registers out_data<=mem_rd_data and out_addr<=cur_addr.
  - Sets out_last=1 when remaining==1.
  - Goes to SEND.
- SEND:
  - out_valid=1. out_addr, out_data and out_last are held stable until out_valid&&out_ready.
  - On transfer: remaining-=1 and cur_addr+=1 modulo 2^ADDR_W (1023 wraps to 0).
  - After transfer, out_last goes to DONE; otherwise the next state is READ.
  - out_valid is never withdrawn without a handshake, except on reset.
- DONE (1 cycle): done=1, busy=0 on exit, back to IDLE.
- Minimum throughput: 3 cycles per word (READ, WAIT, SEND with out_ready held high).
- Latency: dump_en accepted at cycle t with halted=1 gives the first out_valid at t+4 (ARM t+1, READ t+2, WAIT t+3, SEND t+4).
- Abort, halted sampled 0 in READ, WAIT or SEND:
  - aborted<=1.
  - A word already in WAIT/SEND is still presented, with out_last forced to 1, and must complete its handshake. Then DONE.
  - Abort sampled in READ: the read result is discarded and no further word is presented; go to DONE.
- word_count=2^ADDR_W dumps all of Mem starting at start_addr, wrapping once.
- mem_rd_en is high only in READ: exactly one read per emitted or discarded word.

Decomposition:
- Shared package mips32_dbg_pkg:
  - dump_state_t enum (IDLE, ARM, READ, WAIT, SEND, DONE).
  - Default ADDR_W/DATA_W localparams, kept consistent with the pipe_MIPS32 Mem depth.
- Single module. No sub-module: the FSM plus datapath registers are under 200 lines.

Test Plan:
- Basic dump: Mem[120]=85, Mem[121]=130, halted=1; dump_en with start_addr=120, word_count=2, out_ready=1.
  -> (120,85,last=0) at t+4, then (121,130,last=1) at t+7; done pulse at t+8.
- Backpressure: same setup with out_ready low for 5 cycles in SEND.
  -> out_valid, out_addr and out_data held constant; no second mem_rd_en until the handshake.
- Empty and wait-for-halt:
  - word_count=0 -> done 2 cycles after dump_en; out_valid never rises.
  - halted=0 at dump_en -> busy stays 1 in ARM; first word appears 3 cycles after halted rises.
- Wrap: Mem[1023]=7, Mem[0]=9; start_addr=1023, word_count=2.
  -> (1023,7), then (0,9,last=1).
- Abort: halted drops while the first of 4 words is in SEND with out_ready=0.
  -> that word is shown with last=1; after the handshake, done=1, aborted=1, and no further reads.
- Reset mid-dump: rst_n low during WAIT of word 2.
  -> all outputs 0 immediately; no done pulse; a new dump_en after release works normally.

Source files
------------

// File: rtl/mips32_dbg_pkg.sv
// Shared debug-side definitions for the pipe_MIPS32 memory read-back path.
package mips32_dbg_pkg;

  localparam int unsigned MEM_ADDR_W = 10;
  localparam int unsigned MEM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    READ,
    WAIT,
    SEND,
    DONE
  } dump_state_t;

endpackage

// File: rtl/mem_dump_reader.sv
// Streams a window of Mem out as (address, data) pairs once the CPU has halted.
// One synchronous read per word; the word is held on a valid/ready port until accepted.
module mem_dump_reader
  import mips32_dbg_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              halted,
  input  logic              dump_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  dump_state_t state_q, state_d;

  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic              mem_rd_en_q, mem_rd_en_d;
  logic [ADDR_W-1:0] mem_rd_addr_q, mem_rd_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  logic xfer;
  assign xfer = out_valid_q && out_ready;

  // State register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a dropped halt ends the dump after any word in flight.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (dump_en) state_d = ARM;
      ARM: begin
        if (remaining_q == '0) state_d = DONE;
        else if (halted)       state_d = READ;
      end
      READ:    state_d = halted ? WAIT : DONE;
      WAIT:    state_d = SEND;
      SEND: begin
        if (xfer) state_d = (out_last_q || !halted) ? DONE : READ;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output next values; strobes are decoded from the next state
  // so the registered outputs line up with the state they belong to.
  always_comb begin
    cur_addr_d    = cur_addr_q;
    remaining_d   = remaining_q;
    out_addr_d    = out_addr_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    aborted_d     = aborted_q;
    mem_rd_en_d   = (state_d == READ);
    out_valid_d   = (state_d == SEND);
    busy_d        = (state_d != IDLE);
    done_d        = (state_d == DONE);

    case (state_q)
      IDLE: begin
        if (dump_en) begin
          cur_addr_d  = start_addr;
          remaining_d = word_count;
          aborted_d   = 1'b0;
        end
      end
      READ: begin
        if (!halted) aborted_d = 1'b1;
      end
      WAIT: begin
        out_data_d = mem_rd_data;
        out_addr_d = cur_addr_q;
        out_last_d = (remaining_q == CNT_W'(1)) || !halted;
        if (!halted) aborted_d = 1'b1;
      end
      SEND: begin
        if (!halted) begin
          aborted_d  = 1'b1;
          out_last_d = 1'b1;
        end
        if (xfer) begin
          remaining_d = remaining_q - CNT_W'(1);
          cur_addr_d  = cur_addr_q + ADDR_W'(1);
          out_last_d  = 1'b0;
        end
      end
      default: ;
    endcase

    mem_rd_addr_d = (state_d == READ) ? cur_addr_d : mem_rd_addr_q;
  end

  // Datapath and output registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cur_addr_q    <= '0;
      remaining_q   <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_rd_addr_q <= '0;
      out_valid_q   <= 1'b0;
      out_addr_q    <= '0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      cur_addr_q    <= cur_addr_d;
      remaining_q   <= remaining_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_rd_addr_q <= mem_rd_addr_d;
      out_valid_q   <= out_valid_d;
      out_addr_q    <= out_addr_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
    end
  end

  assign mem_rd_en   = mem_rd_en_q;
  assign mem_rd_addr = mem_rd_addr_q;
  assign out_valid   = out_valid_q;
  assign out_addr    = out_addr_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: per-cycle vector tables plus hand-written
// sequences for backpressure, halt wait, abort and mid-dump reset.
module tb_mem_dump_reader;

  logic        clk1;
  logic        rst_n;
  logic        halted;
  logic        dump_en;
  logic [9:0]  start_addr;
  logic [10:0] word_count;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        aborted;

  mem_dump_reader dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .halted     (halted),
    .dump_en    (dump_en),
    .start_addr (start_addr),
    .word_count (word_count),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Synchronous memory: data valid the cycle after the read strobe.
  logic [31:0] mem [1024];
  always @(posedge clk1) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  typedef struct {
    logic        rdy;
    logic        hlt;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        valid;
    logic [9:0]  addr;
    logic [31:0] data;
    logic        last;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vec [16];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic vec_t mk(logic rdy, logic hlt, logic rd_en, logic [9:0] rd_addr,
                              logic valid, logic [9:0] addr, logic [31:0] data,
                              logic last, logic bsy, logic dn);
    vec_t v;
    v.rdy = rdy; v.hlt = hlt; v.rd_en = rd_en; v.rd_addr = rd_addr; v.valid = valid;
    v.addr = addr; v.data = data; v.last = last; v.busy = bsy; v.done = dn;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  // Drive dump_en for one cycle; returns in the cycle after acceptance (ARM).
  task automatic start_dump(input logic [9:0] sa, input logic [10:0] wc);
    start_addr = sa;
    word_count = wc;
    dump_en    = 1'b1;
    step();
    dump_en    = 1'b0;
  endtask

  task automatic apply_vectors(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      out_ready = vec[i].rdy;
      halted    = vec[i].hlt;
      check($sformatf("%s[%0d] rd_en", tag, i), 32'(mem_rd_en), 32'(vec[i].rd_en));
      if (vec[i].rd_en)
        check($sformatf("%s[%0d] rd_addr", tag, i), 32'(mem_rd_addr), 32'(vec[i].rd_addr));
      check($sformatf("%s[%0d] valid", tag, i), 32'(out_valid), 32'(vec[i].valid));
      if (vec[i].valid) begin
        check($sformatf("%s[%0d] addr", tag, i), 32'(out_addr), 32'(vec[i].addr));
        check($sformatf("%s[%0d] data", tag, i), out_data, vec[i].data);
        check($sformatf("%s[%0d] last", tag, i), 32'(out_last), 32'(vec[i].last));
      end
      check($sformatf("%s[%0d] busy", tag, i), 32'(busy), 32'(vec[i].busy));
      check($sformatf("%s[%0d] done", tag, i), 32'(done), 32'(vec[i].done));
      step();
    end
  endtask

  // Two-word dump with out_ready high: ARM, READ, WAIT, SEND, READ, WAIT, SEND, DONE, IDLE.
  task automatic load_two_word(input logic [9:0] a0, input logic [31:0] d0,
                               input logic [9:0] a1, input logic [31:0] d1);
    vec[0] = mk(1, 1, 0, 0,  0, 0,  0,  0, 1, 0);
    vec[1] = mk(1, 1, 1, a0, 0, 0,  0,  0, 1, 0);
    vec[2] = mk(1, 1, 0, 0,  0, 0,  0,  0, 1, 0);
    vec[3] = mk(1, 1, 0, 0,  1, a0, d0, 0, 1, 0);
    vec[4] = mk(1, 1, 1, a1, 0, 0,  0,  0, 1, 0);
    vec[5] = mk(1, 1, 0, 0,  0, 0,  0,  0, 1, 0);
    vec[6] = mk(1, 1, 0, 0,  1, a1, d1, 1, 1, 0);
    vec[7] = mk(1, 1, 0, 0,  0, 0,  0,  0, 1, 1);
    vec[8] = mk(1, 1, 0, 0,  0, 0,  0,  0, 0, 0);
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < 40) begin
      step();
      k++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"},    32'(busy),        32'd0);
    check({tag, " done"},    32'(done),        32'd0);
    check({tag, " valid"},   32'(out_valid),   32'd0);
    check({tag, " rd_en"},   32'(mem_rd_en),   32'd0);
    check({tag, " rd_addr"}, 32'(mem_rd_addr), 32'd0);
    check({tag, " addr"},    32'(out_addr),    32'd0);
    check({tag, " data"},    out_data,         32'd0);
    check({tag, " last"},    32'(out_last),    32'd0);
    check({tag, " aborted"}, 32'(aborted),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hDEAD_0000 + 32'(i);
    mem[120] = 32'd85;  mem[121] = 32'd130;
    mem[1023] = 32'd7;  mem[0] = 32'd9;
    mem[200] = 32'd11;  mem[201] = 32'd22; mem[202] = 32'd33; mem[203] = 32'd44;

    rst_n = 1'b0; halted = 1'b1; dump_en = 1'b0; out_ready = 1'b1;
    start_addr = '0; word_count = '0;
    #1;
    check_all_zero("reset");
    step(); step();
    rst_n = 1'b1;
    step();

    // Basic two-word dump.
    start_dump(10'd120, 11'd2);
    load_two_word(10'd120, 32'd85, 10'd121, 32'd130);
    apply_vectors(9, "basic");

    // Address wrap 1023 -> 0.
    start_dump(10'd1023, 11'd2);
    load_two_word(10'd1023, 32'd7, 10'd0, 32'd9);
    apply_vectors(9, "wrap");

    // Empty dump: done two cycles after dump_en, no output.
    start_dump(10'd5, 11'd0);
    vec[0] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    vec[1] = mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    vec[2] = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    apply_vectors(3, "empty");

    // Backpressure: word held for several cycles, no second read before handshake.
    out_ready = 1'b0;
    start_dump(10'd120, 11'd2);
    step(); step(); step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp[%0d] valid", i), 32'(out_valid),   32'd1);
      check($sformatf("bp[%0d] addr", i),  32'(out_addr),    32'd120);
      check($sformatf("bp[%0d] data", i),  out_data,         32'd85);
      check($sformatf("bp[%0d] rd_en", i), 32'(mem_rd_en),   32'd0);
      step();
    end
    check("bp held valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    step();
    check("bp next rd_en",   32'(mem_rd_en),   32'd1);
    check("bp next rd_addr", 32'(mem_rd_addr), 32'd121);
    wait_done("bp");

    // Wait for halt: stays in ARM, first word three cycles after halted rises.
    halted = 1'b0;
    start_dump(10'd121, 11'd1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("halt_wait[%0d] busy", i),  32'(busy),      32'd1);
      check($sformatf("halt_wait[%0d] rd_en", i), 32'(mem_rd_en), 32'd0);
      check($sformatf("halt_wait[%0d] valid", i), 32'(out_valid), 32'd0);
      step();
    end
    halted = 1'b1;
    step();
    check("halt rd_en",   32'(mem_rd_en),   32'd1);
    check("halt rd_addr", 32'(mem_rd_addr), 32'd121);
    step();
    check("halt wait valid", 32'(out_valid), 32'd0);
    step();
    check("halt valid", 32'(out_valid), 32'd1);
    check("halt addr",  32'(out_addr),  32'd121);
    check("halt data",  out_data,       32'd130);
    check("halt last",  32'(out_last),  32'd1);
    wait_done("halt");

    // Abort while the first of four words waits in SEND.
    out_ready = 1'b0;
    start_dump(10'd200, 11'd4);
    step(); step(); step();
    check("abort pre valid", 32'(out_valid), 32'd1);
    check("abort pre last",  32'(out_last),  32'd0);
    halted = 1'b0;
    step();
    check("abort valid",   32'(out_valid), 32'd1);
    check("abort addr",    32'(out_addr),  32'd200);
    check("abort data",    out_data,       32'd11);
    check("abort last",    32'(out_last),  32'd1);
    check("abort flag",    32'(aborted),   32'd1);
    out_ready = 1'b1;
    step();
    check("abort done",    32'(done),      32'd1);
    check("abort vdrop",   32'(out_valid), 32'd0);
    check("abort rd_en0",  32'(mem_rd_en), 32'd0);
    step();
    check("abort idle",    32'(busy),      32'd0);
    check("abort rd_en1",  32'(mem_rd_en), 32'd0);
    halted = 1'b1;
    step();
    check("abort sticky",  32'(aborted),   32'd1);
    check("abort rd_en2",  32'(mem_rd_en), 32'd0);
    start_dump(10'd0, 11'd0);
    check("abort cleared", 32'(aborted),   32'd0);
    step(); step();

    // Reset during WAIT of word 2, then a normal dump.
    start_dump(10'd120, 11'd2);
    step(); step(); step(); step(); step();
    check("rst pre busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst mid");
    for (int i = 0; i < 2; i++) begin
      step();
      check($sformatf("rst hold[%0d] done", i), 32'(done), 32'd0);
    end
    rst_n = 1'b1;
    step();
    start_dump(10'd120, 11'd2);
    load_two_word(10'd120, 32'd85, 10'd121, 32'd130);
    apply_vectors(9, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
